// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-code bundle between the scanner and its environment.
// The scanner side uses the slave modport; the pad/keypad side uses master.
interface keypad_scanner_if;
  logic [3:0] rows_raw;
  logic [3:0] col_drive;
  logic [3:0] rows;
  logic [3:0] col;
  logic       key_valid;
  logic       key_pulse;

  modport master (
    output rows_raw,
    input  col_drive, rows, col, key_valid, key_pulse
  );

  modport slave (
    input  rows_raw,
    output col_drive, rows, col, key_valid, key_pulse
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with row synchronizer, press/release debounce
// and a one-cycle strobe per accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV  = 1000,
  parameter int DB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.slave  kp_io
);

  localparam int DW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_RELEASE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, rows_s_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] db_q, db_d;
  logic [3:0]    col_drive_q, col_drive_d;
  logic [3:0]    cap_row_q, cap_row_d;
  logic [3:0]    cap_col_q, cap_col_d;
  logic [3:0]    rows_q, rows_d;
  logic [3:0]    col_q, col_d;
  logic          key_pulse_q, key_pulse_d;

  logic [3:0] col_next;
  logic       rows_onehot;
  logic       cap_bit_seen;

  assign col_next     = {col_drive_q[2:0], col_drive_q[3]};
  assign rows_onehot  = (rows_s_q != 4'd0) && ((rows_s_q & (rows_s_q - 4'd1)) == 4'd0);
  assign cap_bit_seen = (rows_s_q & cap_row_q) != 4'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      rows_s_q    <= '0;
      state_q     <= SCAN;
      dwell_q     <= '0;
      db_q        <= '0;
      col_drive_q <= 4'b0001;
      cap_row_q   <= '0;
      cap_col_q   <= '0;
      rows_q      <= '0;
      col_q       <= '0;
      key_pulse_q <= 1'b0;
    end else begin
      sync1_q     <= kp_io.rows_raw;
      rows_s_q    <= sync1_q;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      col_drive_q <= col_drive_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      rows_q      <= rows_d;
      col_q       <= col_d;
      key_pulse_q <= key_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    db_d        = db_q;
    col_drive_d = col_drive_q;
    cap_row_d   = cap_row_q;
    cap_col_d   = cap_col_q;
    rows_d      = rows_q;
    col_d       = col_q;
    key_pulse_d = 1'b0;
    unique case (state_q)
      SCAN: begin
        // Rows are only trusted on the last dwell cycle, once they have settled.
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (rows_onehot) begin
            cap_row_d = rows_s_q;
            cap_col_d = col_drive_q;
            db_d      = '0;
            state_d   = DB_PRESS;
          end else begin
            col_drive_d = col_next;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DB_PRESS: begin
        if (rows_s_q != cap_row_q) begin
          state_d     = SCAN;
          col_drive_d = col_next;
          dwell_d     = '0;
          db_d        = '0;
        end else if (db_q == DB_LAST) begin
          state_d     = HELD;
          rows_d      = cap_row_q;
          col_d       = cap_col_q;
          key_pulse_d = 1'b1;
          db_d        = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      HELD: begin
        if (!cap_bit_seen) begin
          state_d = DB_RELEASE;
          db_d    = '0;
        end
      end
      DB_RELEASE: begin
        if (cap_bit_seen) begin
          state_d = HELD;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d     = SCAN;
          col_drive_d = col_next;
          dwell_d     = '0;
          db_d        = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    kp_io.col_drive = col_drive_q;
    kp_io.rows      = rows_q;
    kp_io.col       = col_q;
    kp_io.key_valid = (state_q == HELD) || (state_q == DB_RELEASE);
    kp_io.key_pulse = key_pulse_q;
  end

endmodule
